cnn_line_buffer_window: RTL

//  Upstream feeder of the 5x5 convolution kernel stage. Accepts a raster-order pixel stream,
//  one pixel per valid cycle, for an IMG_W x IMG_H frame. Keeps KY-1 previous rows in line

---
 rtl/cnn_pkg.sv | 22 ++
 rtl/cnn_row_buffer.sv | 38 +++
 rtl/cnn_line_buffer_window.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN front-end stages.
// Holds the default frame/kernel geometry, the derived counter and window
// widths, and the helper that maps a window (row, col) to its flat element index.
package cnn_pkg;

    localparam int I_F_BW = 8;   // bits per pixel (unsigned)
    localparam int KX     = 5;   // window width
    localparam int KY     = 5;   // window height
    localparam int IMG_W  = 28;  // pixels per row
    localparam int IMG_H  = 28;  // rows per frame

    localparam int COL_BW = $clog2(IMG_W);
    localparam int ROW_BW = $clog2(IMG_H);
    localparam int WIN_BW = KX * KY * I_F_BW;

    // Flat element index of window position (r, c); r=0 is the oldest row,
    // c=0 the leftmost column. This is the kernel's weight ordering.
    function automatic int win_idx(input int r, input int c, input int kx);
        return r * kx + c;
    endfunction

endpackage

// File: rtl/cnn_row_buffer.sv
// One line of pixel history for the window generator.
// A DEPTH-entry circular RAM addressed by the column counter of the owner.
// The read is combinational on the current address and the write lands at the
// clock edge, so dout_o is the value stored one full row earlier at this column
// (read-before-write). Cascading instances gives successively older rows.
// Ports:
//   clk     clock, rising edge
//   en_i    write enable (one accepted pixel)
//   addr_i  column index of the pixel being accepted
//   din_i   pixel to store
//   dout_o  pixel stored at addr_i one row ago
module cnn_row_buffer
    import cnn_pkg::*;
#(
    parameter int DEPTH = IMG_W,
    parameter int WIDTH = I_F_BW,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    // Contents are deliberately not reset: nothing downstream looks at a tap
    // until the whole row has been rewritten since the last reset.
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign dout_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[addr_i] <= din_i;
        end
    end

endmodule

// File: rtl/cnn_line_buffer_window.sv
// KX x KY sliding-window generator feeding the convolution kernel stage.
// Takes a raster-order pixel stream (gaps allowed, no backpressure), keeps
// KY-1 previous rows in cascaded row buffers, and emits the full window,
// packed flat, one cycle after every pixel whose window lies fully inside
// the frame.
// Ports:
//   clk          clock, rising edge
//   reset        synchronous active-high reset
//   i_in_valid   pixel strobe
//   i_in_pixel   raster-order pixel
//   o_ot_valid   1-cycle pulse per window
//   o_ot_fmap    packed window, element e=r*KX+c at [e*I_F_BW +: I_F_BW]
//   o_frame_done pulses with the last window of a frame
module cnn_line_buffer_window #(
    parameter int IMG_W  = cnn_pkg::IMG_W,
    parameter int IMG_H  = cnn_pkg::IMG_H,
    parameter int KX     = cnn_pkg::KX,
    parameter int KY     = cnn_pkg::KY,
    parameter int I_F_BW = cnn_pkg::I_F_BW
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_in_valid,
    input  logic [I_F_BW-1:0]         i_in_pixel,
    output logic                      o_ot_valid,
    output logic [KX*KY*I_F_BW-1:0]   o_ot_fmap,
    output logic                      o_frame_done
);
    import cnn_pkg::*;

    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);
    localparam int WBW = KX * KY * I_F_BW;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST_WIN = CW'(KX - 1);
    localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(KY - 1);

    // ---------------------------------------------------------------
    // Position counters
    // ---------------------------------------------------------------
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          acc;        // pixel accepted this cycle
    logic          col_last;
    logic          row_last;
    logic          win_emit;   // accepted pixel completes an in-frame window
    logic          frame_end;

    // Reset takes priority over a simultaneous pixel, which is dropped.
    assign acc       = i_in_valid & ~reset;
    assign col_last  = (col_q == COL_LAST);
    assign row_last  = (row_q == ROW_LAST);
    assign win_emit  = acc && (row_q >= ROW_FIRST_WIN) && (col_q >= COL_FIRST_WIN);
    assign frame_end = win_emit && col_last && row_last;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (acc) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // ---------------------------------------------------------------
    // Row buffer cascade: buffer k delivers the pixel from k+1 rows above
    // at the current column.
    // ---------------------------------------------------------------
    logic [I_F_BW-1:0] lb_din  [KY-1];
    logic [I_F_BW-1:0] lb_dout [KY-1];

    for (genvar k = 0; k < KY - 1; k++) begin : g_rb
        if (k == 0) begin : g_head
            assign lb_din[k] = i_in_pixel;
        end else begin : g_tail
            assign lb_din[k] = lb_dout[k-1];
        end

        cnn_row_buffer #(
            .DEPTH (IMG_W),
            .WIDTH (I_F_BW),
            .AW    (CW)
        ) u_rb (
            .clk    (clk),
            .en_i   (acc),
            .addr_i (col_q),
            .din_i  (lb_din[k]),
            .dout_o (lb_dout[k])
        );
    end

    // ---------------------------------------------------------------
    // Window register array. Every accepted pixel shifts all rows left; the
    // new right column is oldest row on top, live pixel at the bottom.
    // ---------------------------------------------------------------
    logic [I_F_BW-1:0] win_q   [KY][KX];
    logic [I_F_BW-1:0] win_d   [KY][KX];
    logic [I_F_BW-1:0] new_col [KY];
    logic [WBW-1:0]    fmap_d;

    always_comb begin
        for (int r = 0; r < KY; r++) begin
            new_col[r] = (r == KY - 1) ? i_in_pixel : lb_dout[KY-2-r];
        end
    end

    always_comb begin
        for (int r = 0; r < KY; r++) begin
            for (int c = 0; c < KX; c++) begin
                win_d[r][c] = win_q[r][c];
            end
        end
        if (acc) begin
            for (int r = 0; r < KY; r++) begin
                for (int c = 0; c < KX - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][KX-1] = new_col[r];
            end
        end
    end

    always_comb begin
        fmap_d = '0;
        for (int r = 0; r < KY; r++) begin
            for (int c = 0; c < KX; c++) begin
                fmap_d[win_idx(r, c, KX)*I_F_BW +: I_F_BW] = win_d[r][c];
            end
        end
    end

    // Window storage needs no reset: output gating hides stale contents.
    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

    // ---------------------------------------------------------------
    // Registered outputs; fmap only reloads on an emitted window so it
    // holds the last window through gaps and non-window pixels.
    // ---------------------------------------------------------------
    logic           valid_q;
    logic           done_q;
    logic [WBW-1:0] fmap_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            fmap_q  <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= win_emit;
            done_q  <= frame_end;
            if (win_emit) begin
                fmap_q <= fmap_d;
            end
        end
    end

    assign o_ot_valid   = valid_q;
    assign o_frame_done = done_q;
    assign o_ot_fmap    = fmap_q;

endmodule
